// File: rtl/decode_dispatch_ctrl.sv
// Decode stage: latches the fetched word, decodes it, dispatches one execute FSM.
// Define DC_TIMEOUT_EN to bound the wait for the execute FSM by TIMEOUT cycles.
module decode_dispatch_ctrl #(
  parameter int WIDTH   = 32,
  parameter int REGW    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_dc,
  input  logic [WIDTH-1:0] ir,
  input  logic             alu_done,
  input  logic             load_done,
  input  logic             store_done,
  output logic             go_alu,
  output logic             go_load,
  output logic             go_store,
  output logic [REGW-1:0]  rd_sel,
  output logic [REGW-1:0]  rs_sel,
  output logic [REGW-1:0]  rt_sel,
  output logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             dc_done,
  output logic             illegal,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_WAIT,
    S_FINISH
  } state_t;

  localparam logic [5:0] OP_ALU   = 6'b100000;
  localparam logic [5:0] OP_LOAD  = 6'b011000;
  localparam logic [5:0] OP_STORE = 6'b011001;

  state_t           state_q, state_d;
  logic             go_dc_q, go_dc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [REGW-1:0]  rd_q, rd_d;
  logic [REGW-1:0]  rs_q, rs_d;
  logic [REGW-1:0]  rt_q, rt_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic             go_alu_q, go_alu_d;
  logic             go_load_q, go_load_d;
  logic             go_store_q, go_store_d;
  logic             busy_q, busy_d;
  logic             dc_done_q, dc_done_d;
  logic             illegal_q, illegal_d;
  logic             accept;
  logic             fin;
  logic [5:0]       opcode;

`ifdef DC_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  assign accept = (state_q == S_IDLE) && go_dc && !go_dc_q;
  assign opcode = ir_q[31:26];
  // Only the done of the FSM we actually enabled counts.
  assign fin = (go_alu_q & alu_done) |
               (go_load_q & load_done) |
               (go_store_q & store_done);

  always_comb begin
    state_d    = state_q;
    go_dc_d    = go_dc;
    ir_d       = ir_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    imm_d      = imm_q;
    go_alu_d   = go_alu_q;
    go_load_d  = go_load_q;
    go_store_d = go_store_q;
    busy_d     = busy_q;
    dc_done_d  = 1'b0;
    illegal_d  = illegal_q;
`ifdef DC_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_LATCH;
          ir_d      = ir;
          illegal_d = 1'b0;
          busy_d    = 1'b1;
`ifdef DC_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_LATCH: begin
        rd_d  = ir_q[25:21];
        rs_d  = ir_q[20:16];
        rt_d  = ir_q[15:11];
        imm_d = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
`ifdef DC_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
        case (opcode)
          OP_ALU:   go_alu_d   = 1'b1;
          OP_LOAD:  go_load_d  = 1'b1;
          OP_STORE: go_store_d = 1'b1;
          default: begin
            state_d   = S_FINISH;
            illegal_d = 1'b1;
            dc_done_d = 1'b1;
          end
        endcase
      end
      S_WAIT: begin
        if (fin) begin
          state_d    = S_FINISH;
          go_alu_d   = 1'b0;
          go_load_d  = 1'b0;
          go_store_d = 1'b0;
          dc_done_d  = 1'b1;
        end
`ifdef DC_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d    = S_FINISH;
          go_alu_d   = 1'b0;
          go_load_d  = 1'b0;
          go_store_d = 1'b0;
          dc_done_d  = 1'b1;
          timeout_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      go_dc_q    <= 1'b1;
      ir_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      go_alu_q   <= 1'b0;
      go_load_q  <= 1'b0;
      go_store_q <= 1'b0;
      busy_q     <= 1'b0;
      dc_done_q  <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef DC_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      go_dc_q    <= go_dc_d;
      ir_q       <= ir_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      imm_q      <= imm_d;
      go_alu_q   <= go_alu_d;
      go_load_q  <= go_load_d;
      go_store_q <= go_store_d;
      busy_q     <= busy_d;
      dc_done_q  <= dc_done_d;
      illegal_q  <= illegal_d;
`ifdef DC_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign go_alu   = go_alu_q;
  assign go_load  = go_load_q;
  assign go_store = go_store_q;
  assign rd_sel   = rd_q;
  assign rs_sel   = rs_q;
  assign rt_sel   = rt_q;
  assign imm      = imm_q;
  assign busy     = busy_q;
  assign dc_done  = dc_done_q;
  assign illegal  = illegal_q;
`ifdef DC_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule
